counter_trig_decoder: RTL and testbench
=======================================

# counter_trig_decoder

Receive-side companion to the trigger-output counter: it takes the counter's per-bit carry-out trigger vector and the counter's enable, rebuilds a cycle-accurate shadow copy of the count, and reports loss of synchronisation. It sits downstream of a `counter` instance, or at the far end of a trigger bus, wherever the count value itself is not routed.

## Interface
- `WIDTH`, default 4: counter width; must match the upstream counter, ≥1.
- `clk` input 1: single clock, shared with the upstream counter.
- `rst` input 1: synchronous, active-high reset.
- `n_en` input 1: the same active-low enable that drives the upstream counter.
- `trig_in` input WIDTH: upstream trigger vector. Bit i pulses for one cycle when upstream count bit i falls 1→0.
- `count` output WIDTH: reconstructed count, cycle-aligned with the upstream count once locked.
- `locked` output 1: high while `count` is known valid.
- `err` output 1: one-cycle pulse when a trigger mismatch is detected in LOCKED.
- `err_cnt` output 8: saturating mismatch counter; present only with `COUNTER_TRIG_DECODER_ERRCNT_EN`.

## Operation
- Internal registers: `count`, `prev_count` (value of `count` one cycle earlier), state.
- `expected = prev_count & ~count`. This matches the upstream rule that trig equals old count AND NOT new count.
- Arithmetic is modulo 2**WIDTH. Increment wraps from all-ones to 0.
- States: SEARCH, LOCKED.
- SEARCH (entered on reset):
  - `count` holds its value; `locked` is 0; `err` is never raised.
  - If `trig_in == '1` (full wrap, so upstream count is now 0): go to LOCKED. Set `count` to 1 if `n_en == 0`, else 0.
  - Any other `trig_in` value: stay in SEARCH.
- LOCKED:
  - Every cycle, `count` increments if `n_en == 0` and holds otherwise. `prev_count <= count`.
  - If `trig_in != expected`: pulse `err`, go to SEARCH, and `count` holds the value it had in that cycle.
  - This covers nonzero triggers while disabled, missing triggers, and non-contiguous patterns.
- Only full-wrap acquisition is supported. Partial patterns (for example `0011`) never lock.
- With WIDTH=1, `'1 == 1`, so acquisition occurs on every upstream 1→0 transition.

## Timing
- Reset values: `count=0`, `prev_count=0`, `locked=0`, `err=0`, `err_cnt=0`, state SEARCH.
- All outputs are registered; there are no combinational paths from input to output.
- `trig_in` is compared at the edge after it becomes visible, so `err` rises one cycle after the offending `trig_in`.
- Lock latency: `locked` rises one cycle after `trig_in == '1` is presented. From that point `count` equals the upstream count every cycle.
- `rst` mid-operation: all state returns to reset values at the next edge, regardless of `trig_in` or `n_en`.
- Simultaneous mismatch and `'1` while in LOCKED: the mismatch wins. The block goes to SEARCH and re-locks on the next full wrap, not on the same one.

## Configuration
- `COUNTER_TRIG_DECODER_ERRCNT_EN` defined:
  - `err_cnt` port exists.
  - It increments on each `err` pulse and saturates at 255.
  - It is cleared only by `rst`.
- Not defined: the port and its register are absent. All other behaviour is identical.

## Structure
- Shared package `counter_trig_pkg`:
  - state enum `trig_dec_state_e` {SEARCH, LOCKED};
  - `ERRCNT_W = 8`;
  - function `trig_expected(prev, cur)` returning `prev & ~cur`, reused by the bench scoreboard.
- One sub-module: `trig_err_counter`, the saturating counter, instantiated only under the macro.

## Test plan
(All scenarios use WIDTH=4 with an upstream `counter` instance sharing `clk` and `n_en`.)
- **Acquisition:** release `rst`, upstream counts freely.
  - `locked=0` until upstream wraps 15→0.
  - One cycle later `locked=1`, and `count` tracks upstream for the next 32 cycles with `err=0`.
- **Enable pause:** while locked, `n_en=1` for 3 cycles.
  - `count` holds at its value, `trig_in=0`, no `err`.
  - After re-enable, the 1→2 step shows `trig_in=0001` and still no `err`.
- **Injected glitch:** force `trig_in=0100` for one cycle when 0001 is expected.
  - `err` pulses one cycle later and `locked=0`.
  - Re-lock occurs after the next upstream wrap.
- **Spurious trigger while disabled:** `n_en=1`, inject `trig_in=0001`.
  - `err=1`, then SEARCH.
- **Reset mid-lock:** assert `rst` for 1 cycle at count 9.
  - Next cycle `count=0`, `locked=0`, `err_cnt=0`.
- **Error count saturation (macro on):** inject 300 glitches, each followed by re-lock.
  - `err_cnt` stops at 255.
- **Macro off:** elaborate without `COUNTER_TRIG_DECODER_ERRCNT_EN` and rerun the scenarios above, excluding `err_cnt` checks; all pass.

Source files
------------

// File: rtl/counter_trig_pkg.sv
// Shared types and helpers for the trigger-vector decoder and its bench.
package counter_trig_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } trig_dec_state_e;

    localparam int unsigned ERRCNT_W = 8;

    // Trigger rule of the upstream counter: bits that fell 1->0. Widths up to 32.
    function automatic logic [31:0] trig_expected(input logic [31:0] prev, input logic [31:0] cur);
        return prev & ~cur;
    endfunction

endpackage

// File: rtl/counter_trig_decoder_if.sv
// Trigger bus between an upstream counter (master) and the decoder (slave).
// err_cnt exists only when COUNTER_TRIG_DECODER_ERRCNT_EN is defined.
interface counter_trig_decoder_if #(
    parameter int unsigned WIDTH = 4
);
    import counter_trig_pkg::*;

    logic             n_en;
    logic [WIDTH-1:0] trig_in;
    logic [WIDTH-1:0] count;
    logic             locked;
    logic             err;
`ifdef COUNTER_TRIG_DECODER_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_cnt;

    modport master (output n_en, trig_in, input count, locked, err, err_cnt);
    modport slave  (input n_en, trig_in, output count, locked, err, err_cnt);
`else
    modport master (output n_en, trig_in, input count, locked, err);
    modport slave  (input n_en, trig_in, output count, locked, err);
`endif

endinterface

// File: rtl/trig_err_counter.sv
// Saturating event counter for decoder mismatch pulses.
// Compiled only when COUNTER_TRIG_DECODER_ERRCNT_EN is defined.
`ifdef COUNTER_TRIG_DECODER_ERRCNT_EN
module trig_err_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule
`endif

// File: rtl/counter_trig_decoder.sv
// Rebuilds a shadow count from an upstream counter's carry-out triggers and flags loss of sync.
// Optional saturating error counter under COUNTER_TRIG_DECODER_ERRCNT_EN.
module counter_trig_decoder
    import counter_trig_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    counter_trig_decoder_if.slave  bus
);

    trig_dec_state_e  state, next_state;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] expected;
    logic             locked_q;
    logic             err_q, err_d;

    always_comb begin
        next_state = state;
        count_d    = count_q;
        prev_d     = prev_q;
        err_d      = 1'b0;
        expected   = WIDTH'(trig_expected(32'(prev_q), 32'(count_q)));

        unique case (state)
            SEARCH: begin
                // A full wrap means upstream is at 0; prev is seeded to that 0 so the
                // first locked comparison sees the 0->next step correctly.
                if (bus.trig_in == '1) begin
                    next_state = LOCKED;
                    count_d    = bus.n_en ? '0 : WIDTH'(1);
                    prev_d     = '0;
                end
            end
            LOCKED: begin
                if (bus.trig_in != expected) begin
                    next_state = SEARCH;
                    err_d      = 1'b1;
                end else begin
                    prev_d = count_q;
                    if (!bus.n_en) begin
                        count_d = count_q + WIDTH'(1);
                    end
                end
            end
            default: next_state = SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SEARCH;
            count_q  <= '0;
            prev_q   <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= next_state;
            count_q  <= count_d;
            prev_q   <= prev_d;
            locked_q <= (next_state == LOCKED);
            err_q    <= err_d;
        end
    end

    assign bus.count  = count_q;
    assign bus.locked = locked_q;
    assign bus.err    = err_q;

`ifdef COUNTER_TRIG_DECODER_ERRCNT_EN
    // Fed from err_d so err_cnt steps on the same edge that raises err.
    trig_err_counter #(
        .W (ERRCNT_W)
    ) u_err_counter (
        .clk (clk),
        .rst (rst),
        .inc (err_d),
        .cnt (bus.err_cnt)
    );
`endif

endmodule

// File: tb/tb_counter_trig_decoder.sv
// Directed bench: a behavioural upstream counter drives the decoder; glitches are overlaid on trig_in.
// Define COUNTER_TRIG_DECODER_ERRCNT_EN to include the err_cnt checks.
module tb_counter_trig_decoder;
    import counter_trig_pkg::*;

    localparam int unsigned WIDTH = 4;

    logic clk = 1'b0;
    logic rst;
    logic up_rst;
    logic [WIDTH-1:0] up_cnt;
    logic [WIDTH-1:0] up_trig;
    int n_tests = 0;
    int n_fail  = 0;

    counter_trig_decoder_if #(.WIDTH(WIDTH)) bus ();

    counter_trig_decoder #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; the upstream counter model advances on the same edge as the DUT.
    task automatic tick();
        logic [WIDTH-1:0] nxt;
        @(posedge clk);
        #1;
        if (up_rst) begin
            up_cnt  = '0;
            up_trig = '0;
        end else if (!bus.n_en) begin
            nxt     = up_cnt + WIDTH'(1);
            up_trig = WIDTH'(trig_expected(32'(up_cnt), 32'(nxt)));
            up_cnt  = nxt;
        end else begin
            up_trig = '0;
        end
        bus.trig_in = up_trig;
    endtask

    task automatic wait_lock(input string tag);
        int i = 0;
        while (!bus.locked && i < 40) begin
            tick();
            i++;
        end
        check(tag, 32'(bus.locked), 32'd1);
        check({tag, "_count"}, 32'(bus.count), 32'(up_cnt));
    endtask

    // Advance while locked until the upstream count reaches val, checking tracking on the way.
    task automatic run_until(input logic [WIDTH-1:0] val);
        int i = 0;
        while (up_cnt != val && i < 40) begin
            tick();
            check("track_count", 32'(bus.count), 32'(up_cnt));
            check("track_err", 32'(bus.err), 32'd0);
            i++;
        end
    endtask

    initial begin
        rst         = 1'b1;
        up_rst      = 1'b1;
        bus.n_en    = 1'b0;
        bus.trig_in = '0;
        up_cnt      = '0;
        up_trig     = '0;
        repeat (2) tick();
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_locked", 32'(bus.locked), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
`ifdef COUNTER_TRIG_DECODER_ERRCNT_EN
        check("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
`endif

        // Acquisition: upstream 1..15 then 0 with trig 1111; lock one cycle later.
        rst    = 1'b0;
        up_rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("search_unlocked", 32'(bus.locked), 32'd0);
        end
        tick();
        check("lock_rise", 32'(bus.locked), 32'd1);
        check("lock_count", 32'(bus.count), 32'd1);
        for (int i = 0; i < 32; i++) begin
            tick();
            check("acq_count", 32'(bus.count), 32'(up_cnt));
            check("acq_err", 32'(bus.err), 32'd0);
            check("acq_locked", 32'(bus.locked), 32'd1);
        end

        // Enable pause at count 1, then the 1->2 step carries trig 0001.
        run_until(4'd1);
        bus.n_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pause_count", 32'(bus.count), 32'd1);
            check("pause_err", 32'(bus.err), 32'd0);
            check("pause_locked", 32'(bus.locked), 32'd1);
        end
        bus.n_en = 1'b0;
        tick();
        check("resume_count", 32'(bus.count), 32'd2);
        tick();
        check("resume_err", 32'(bus.err), 32'd0);
        check("resume_count2", 32'(bus.count), 32'd3);

        // Glitch 0100 where 5->6 gives 0001.
        run_until(4'd6);
        bus.trig_in = 4'b0100;
        tick();
        check("glitch_err", 32'(bus.err), 32'd1);
        check("glitch_locked", 32'(bus.locked), 32'd0);
        check("glitch_count_hold", 32'(bus.count), 32'd6);
        tick();
        check("glitch_err_pulse", 32'(bus.err), 32'd0);
        check("glitch_search", 32'(bus.locked), 32'd0);
        wait_lock("glitch_relock");

        // Full-wrap pattern arriving as a mismatch: error wins, no same-cycle re-lock.
        run_until(4'd10);
        bus.trig_in = '1;
        tick();
        check("simul_err", 32'(bus.err), 32'd1);
        check("simul_locked", 32'(bus.locked), 32'd0);
        tick();
        check("simul_no_relock", 32'(bus.locked), 32'd0);
        wait_lock("simul_relock");

        // Spurious trigger while disabled.
        bus.n_en = 1'b1;
        tick();
        bus.trig_in = 4'b0001;
        tick();
        check("spur_err", 32'(bus.err), 32'd1);
        check("spur_locked", 32'(bus.locked), 32'd0);
        bus.n_en = 1'b0;
        wait_lock("spur_relock");
`ifdef COUNTER_TRIG_DECODER_ERRCNT_EN
        check("err_cnt_three", 32'(bus.err_cnt), 32'd3);
`endif

        // Reset mid-lock at count 9.
        run_until(4'd9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_count", 32'(bus.count), 32'd0);
        check("midrst_locked", 32'(bus.locked), 32'd0);
        check("midrst_err", 32'(bus.err), 32'd0);
`ifdef COUNTER_TRIG_DECODER_ERRCNT_EN
        check("midrst_err_cnt", 32'(bus.err_cnt), 32'd0);
`endif
        wait_lock("midrst_relock");

`ifdef COUNTER_TRIG_DECODER_ERRCNT_EN
        // 300 glitches each followed by re-lock; counter saturates at 255.
        for (int i = 1; i <= 300; i++) begin
            bus.trig_in = up_trig ^ 4'b0100;
            tick();
            if (i == 1)   check("sat_first", 32'(bus.err_cnt), 32'd1);
            if (i == 254) check("sat_254", 32'(bus.err_cnt), 32'd254);
            if (i == 255) check("sat_255", 32'(bus.err_cnt), 32'd255);
            wait_lock("sat_relock");
        end
        check("sat_300", 32'(bus.err_cnt), 32'd255);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
